mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multicycle control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the immediate-extender select (ext_op), ALU operation, register-file, memory, PC and IR write strobes, and mux selects.
- Counts retired instructions. Takes op/funct directly from the IR outputs and zero from the ALU.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- pc_wr  out  1  PC write strobe
- ir_wr  out  1  IR write strobe
- rf_wr  out  1  register-file write strobe
- dm_wr  out  1  data-memory write strobe
- ext_op  out  2  extender select: LOGIC=00, ARITH=01, LUI=10
- alu_op  out  2  ALU operation: ADD=00, SUB=01, OR=10, SLT=11
- alu_src_b  out  1  ALU B operand: 0=rt register, 1=Imm32
- reg_dst  out  2  write-register select: 0=rt, 1=rd, 2=$31
- wd_sel  out  2  write-data select: 0=ALU out, 1=DM data register, 2=PC (already PC+4)
- npc_op  out  2  next-PC select: 0=PC+4, 1=branch, 2=j/jal target, 3=rs (jr)
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Supported instructions and encodings:
  - R-type (op 000000) with funct addu 100001, subu 100011, slt 101010, jr 001000.
  - ori 001101, addiu 001001, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- State encodings: INIT 0, FETCH 1, DECODE 2, EXE 3, ALUWB 4, MEMADR 5, MEMRD 6, MEMWB 7, MEMWR 8, BRANCH 9, JUMP 10.
- Reset:
  - rst_n low immediately forces state=INIT, instr_cnt=0 and all strobes and illegal to 0, including mid-instruction.
  - All selects read 0 during reset.
  - INIT moves to FETCH on the first rising edge after rst_n is released; no strobe is asserted in INIT.
- Outputs are a combinational decode of state plus op/funct. The IR is written only in FETCH, so op/funct are stable from DECODE onward.
- Per-state outputs and next state (unlisted outputs are 0):
  - FETCH: ir_wr=1, pc_wr=1, npc_op=0. Next: DECODE.
  - DECODE: nothing asserted. Next:
    - addu/subu/slt/ori/addiu/lui → EXE.
    - lw/sw → MEMADR.
    - beq → BRANCH.
    - j/jal/jr → JUMP.
    - Any other op, or op=0 with an unlisted funct → FETCH with illegal=1 for this cycle. Not counted as retired.
  - EXE:
    - alu_op: ADD for addu/addiu, SUB for subu, SLT for slt, OR for ori/lui.
    - alu_src_b=1 for I-type.
    - Next: ALUWB.
  - ALUWB: rf_wr=1; reg_dst=1 for R-type, 0 for I-type; wd_sel=0. Next: FETCH.
  - MEMADR: alu_op=ADD, alu_src_b=1. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: next MEMWB.
  - MEMWB: rf_wr=1, reg_dst=0, wd_sel=1. Next: FETCH.
  - MEMWR: dm_wr=1. Next: FETCH.
  - BRANCH: alu_op=SUB, alu_src_b=0, npc_op=1, pc_wr=zero. Next: FETCH.
  - JUMP:
    - pc_wr=1.
    - npc_op=3 for jr, otherwise 2.
    - jal only: rf_wr=1, reg_dst=2, wd_sel=2.
    - Next: FETCH.
- ext_op is driven from DECODE through the final state of the instruction:
  - LOGIC for ori, LUI for lui, ARITH for addiu/lw/sw/beq.
  - LOGIC in FETCH, INIT and for all other instructions.
- Latency in cycles, FETCH to last state inclusive: R-type/I-type ALU 4, lw 5, sw 4, beq 3, j/jal/jr 3.
- instr_cnt increments by 1 on each transition into FETCH from ALUWB, MEMWB, MEMWR, BRANCH or JUMP. A not-taken beq counts. Wraps from all-ones to 0 without a flag.

Decomposition:
- Shared define package holds:
  - EXT select constants LogicEXT / ArithmeticEXT / LUIEXT (00/01/10), shared with the extender.
  - ALU op, NPC op, reg_dst and wd_sel codes.
  - Opcode and funct constants.
  - State encodings.
- One sub-module, mc_ctrl_decode: purely combinational, maps (state, op, funct, zero) to the output bundle and next state.
- mc_ctrl holds the state register and the counter.

Test Plan:
- Reset release, then `ori $1,$0,0x8001` with zero=0:
  - Cycle sequence INIT, FETCH, DECODE, EXE, ALUWB, FETCH.
  - ext_op=00 from DECODE through ALUWB.
  - rf_wr=1 only in ALUWB, with reg_dst=0.
  - instr_cnt=1.
- Sequence lw, sw, lui, addiu:
  - lw takes 5 cycles with MEMWB wd_sel=1.
  - sw asserts dm_wr only in MEMWR.
  - lui drives ext_op=10; addiu/lw/sw drive ext_op=01.
  - instr_cnt=4.
- beq with zero=1 then zero=0: pc_wr=1 with npc_op=1 in the first BRANCH; pc_wr=0 in the second; both count.
- jal then jr:
  - jal JUMP has pc_wr=1, npc_op=2, rf_wr=1, reg_dst=2, wd_sel=2.
  - jr JUMP has npc_op=3 and rf_wr=0.
- op=111111, and op=0 with funct=000000: illegal pulses 1 cycle in DECODE, state returns to FETCH, instr_cnt unchanged.
- Wrap and mid-instruction reset:
  - With CNT_W=4, 16 retires return instr_cnt to 0.
  - rst_n pulled low during MEMRD: state=INIT and all strobes 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle MIPS controller and its datapath.
package mc_ctrl_pkg;

    localparam logic [1:0] LogicEXT      = 2'b00;
    localparam logic [1:0] ArithmeticEXT = 2'b01;
    localparam logic [1:0] LUIEXT        = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_SLT = 2'd3;

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] NPC_BR  = 2'd1;
    localparam logic [1:0] NPC_J   = 2'd2;
    localparam logic [1:0] NPC_JR  = 2'd3;

    localparam logic [1:0] RD_RT = 2'd0;
    localparam logic [1:0] RD_RD = 2'd1;
    localparam logic [1:0] RD_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_DM  = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_JR   = 6'b001000;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXE    = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_e;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       rf_wr;
        logic       dm_wr;
        logic [1:0] ext_op;
        logic [1:0] alu_op;
        logic       alu_src_b;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic [1:0] npc_op;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map of (state, op, funct, zero) to control outputs,
// next state and the retire strobe.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output ctrl_t      ctrl,
    output state_e     state_d,
    output logic       retire
);

    logic is_r, addu, subu, slt, jr, ori, addiu, lui, lw, sw, beq, j, jal;
    logic alu_r, alu_i, mem, jmp;

    assign is_r  = op == OP_RTYPE;
    assign addu  = is_r && funct == F_ADDU;
    assign subu  = is_r && funct == F_SUBU;
    assign slt   = is_r && funct == F_SLT;
    assign jr    = is_r && funct == F_JR;
    assign ori   = op == OP_ORI;
    assign addiu = op == OP_ADDIU;
    assign lui   = op == OP_LUI;
    assign lw    = op == OP_LW;
    assign sw    = op == OP_SW;
    assign beq   = op == OP_BEQ;
    assign j     = op == OP_J;
    assign jal   = op == OP_JAL;
    assign alu_r = addu || subu || slt;
    assign alu_i = ori || addiu || lui;
    assign mem   = lw || sw;
    assign jmp   = j || jal || jr;

    always_comb begin
        ctrl    = '0;
        state_d = S_FETCH;
        retire  = 1'b0;
        // op is stale until the IR is loaded, so the extender only follows it after FETCH
        ctrl.ext_op = (state == S_INIT || state == S_FETCH) ? LogicEXT :
                      lui ? LUIEXT :
                      (addiu || lw || sw || beq) ? ArithmeticEXT : LogicEXT;
        case (state)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                ctrl.ir_wr = 1'b1;
                ctrl.pc_wr = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                state_d = (alu_r || alu_i) ? S_EXE :
                          mem ? S_MEMADR :
                          beq ? S_BRANCH :
                          jmp ? S_JUMP : S_FETCH;
                ctrl.illegal = !(alu_r || alu_i || mem || beq || jmp);
            end
            S_EXE: begin
                ctrl.alu_op    = subu ? ALU_SUB : slt ? ALU_SLT : (ori || lui) ? ALU_OR : ALU_ADD;
                ctrl.alu_src_b = alu_i;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.rf_wr   = 1'b1;
                ctrl.reg_dst = is_r ? RD_RD : RD_RT;
                retire       = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_src_b = 1'b1;
                state_d        = lw ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: state_d = S_MEMWB;
            S_MEMWB: begin
                ctrl.rf_wr  = 1'b1;
                ctrl.wd_sel = WD_DM;
                retire      = 1'b1;
            end
            S_MEMWR: begin
                ctrl.dm_wr = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.npc_op = NPC_BR;
                ctrl.pc_wr  = zero;
                retire      = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_wr   = 1'b1;
                ctrl.npc_op  = jr ? NPC_JR : NPC_J;
                ctrl.rf_wr   = jal;
                ctrl.reg_dst = jal ? RD_RA : RD_RT;
                ctrl.wd_sel  = jal ? WD_PC : WD_ALU;
                retire       = 1'b1;
            end
            default: state_d = S_INIT;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control FSM; holds the state register and the
// retired-instruction counter around the combinational decoder.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_wr,
    output logic             ir_wr,
    output logic             rf_wr,
    output logic             dm_wr,
    output logic [1:0]       ext_op,
    output logic [1:0]       alu_op,
    output logic             alu_src_b,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wd_sel,
    output logic [1:0]       npc_op,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
    ctrl_t            ctrl;
    logic             retire;

    mc_ctrl_decode u_decode (
        .state   (state_q),
        .op      (op),
        .funct   (funct),
        .zero    (zero),
        .ctrl    (ctrl),
        .state_d (state_d),
        .retire  (retire)
    );

    always_comb begin
        instr_cnt_d = retire ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    // INIT decodes to all-zero, so the async reset also clears every strobe and select
    assign pc_wr     = ctrl.pc_wr;
    assign ir_wr     = ctrl.ir_wr;
    assign rf_wr     = ctrl.rf_wr;
    assign dm_wr     = ctrl.dm_wr;
    assign ext_op    = ctrl.ext_op;
    assign alu_op    = ctrl.alu_op;
    assign alu_src_b = ctrl.alu_src_b;
    assign reg_dst   = ctrl.reg_dst;
    assign wd_sel    = ctrl.wd_sel;
    assign npc_op    = ctrl.npc_op;
    assign illegal   = ctrl.illegal;
    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed instruction sequence through mc_ctrl with a 4-bit counter,
// checking state, every control output and the retire count cycle by cycle.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       pc_wr, ir_wr, rf_wr, dm_wr, alu_src_b, illegal;
    logic [1:0] ext_op, alu_op, reg_dst, wd_sel, npc_op;
    logic [3:0] state;
    logic [3:0] instr_cnt;
    int         n = 0;
    int         nf = 0;

    always #5 clk = ~clk;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct     (funct),
        .zero      (zero),
        .pc_wr     (pc_wr),
        .ir_wr     (ir_wr),
        .rf_wr     (rf_wr),
        .dm_wr     (dm_wr),
        .ext_op    (ext_op),
        .alu_op    (alu_op),
        .alu_src_b (alu_src_b),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .npc_op    (npc_op),
        .illegal   (illegal),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    function automatic logic [15:0] ov(input logic pc, ir, rf, dm, input logic [1:0] ext, alu,
                                       input logic sb, input logic [1:0] rd, wd, npc, input logic ill);
        return {pc, ir, rf, dm, ext, alu, sb, rd, wd, npc, ill};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n++;
        assert (got === exp) else begin
            nf++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input string tag, input logic [3:0] st, input logic [15:0] o);
        chk({tag, ".state"}, {12'd0, state}, {12'd0, st});
        chk({tag, ".out"}, {pc_wr, ir_wr, rf_wr, dm_wr, ext_op, alu_op, alu_src_b,
                            reg_dst, wd_sel, npc_op, illegal}, o);
    endtask

    task automatic st(input string tag, input logic [3:0] s, input logic [15:0] o);
        ex(tag, s, o);
        tick();
    endtask

    task automatic fetch(input string tag, input logic [3:0] c, input logic [5:0] o, input logic [5:0] f);
        ex({tag, ".fetch"}, S_FETCH, ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        chk({tag, ".cnt"}, {12'd0, instr_cnt}, {12'd0, c});
        op = o;
        funct = f;
        tick();
    endtask

    initial begin
        #12;
        ex("reset", S_INIT, 16'h0000);
        chk("reset.cnt", {12'd0, instr_cnt}, 16'd0);
        rst_n = 1'b1;
        tick();
        fetch("ori", 4'd0, OP_ORI, 6'd0);
        st("ori.dec",   S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("ori.exe",   S_EXE,    ov(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0));
        st("ori.wb",    S_ALUWB,  ov(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        fetch("lw", 4'd1, OP_LW, 6'd0);
        st("lw.dec",    S_DECODE, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("lw.madr",   S_MEMADR, ov(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        st("lw.mrd",    S_MEMRD,  ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("lw.mwb",    S_MEMWB,  ov(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0));
        fetch("sw", 4'd2, OP_SW, 6'd0);
        st("sw.dec",    S_DECODE, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("sw.madr",   S_MEMADR, ov(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        st("sw.mwr",    S_MEMWR,  ov(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        fetch("lui", 4'd3, OP_LUI, 6'd0);
        st("lui.dec",   S_DECODE, ov(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
        st("lui.exe",   S_EXE,    ov(0, 0, 0, 0, 2, 2, 1, 0, 0, 0, 0));
        st("lui.wb",    S_ALUWB,  ov(0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0));
        fetch("addiu", 4'd4, OP_ADDIU, 6'd0);
        st("addiu.dec", S_DECODE, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("addiu.exe", S_EXE,    ov(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        st("addiu.wb",  S_ALUWB,  ov(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        zero = 1'b1;
        fetch("beq1", 4'd5, OP_BEQ, 6'd0);
        st("beq1.dec",  S_DECODE, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("beq1.br",   S_BRANCH, ov(1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        zero = 1'b0;
        fetch("beq0", 4'd6, OP_BEQ, 6'd0);
        st("beq0.dec",  S_DECODE, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("beq0.br",   S_BRANCH, ov(0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0));
        fetch("jal", 4'd7, OP_JAL, 6'd0);
        st("jal.dec",   S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("jal.jmp",   S_JUMP,   ov(1, 0, 1, 0, 0, 0, 0, 2, 2, 2, 0));
        fetch("jr", 4'd8, OP_RTYPE, F_JR);
        st("jr.dec",    S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("jr.jmp",    S_JUMP,   ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0));
        fetch("ill1", 4'd9, 6'b111111, 6'd0);
        st("ill1.dec",  S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        fetch("ill2", 4'd9, OP_RTYPE, 6'd0);
        st("ill2.dec",  S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        fetch("addu", 4'd9, OP_RTYPE, F_ADDU);
        st("addu.dec",  S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("addu.exe",  S_EXE,    ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("addu.wb",   S_ALUWB,  ov(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        fetch("subu", 4'd10, OP_RTYPE, F_SUBU);
        st("subu.dec",  S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("subu.exe",  S_EXE,    ov(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        st("subu.wb",   S_ALUWB,  ov(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        fetch("slt", 4'd11, OP_RTYPE, F_SLT);
        st("slt.dec",   S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        st("slt.exe",   S_EXE,    ov(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        st("slt.wb",    S_ALUWB,  ov(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            fetch($sformatf("j%0d", i), 4'(12 + i), OP_J, 6'd0);
            st($sformatf("j%0d.dec", i), S_DECODE, ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            st($sformatf("j%0d.jmp", i), S_JUMP,   ov(1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
        end
        fetch("wrap", 4'd0, OP_LW, 6'd0);
        st("lw2.dec",   S_DECODE, ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        st("lw2.madr",  S_MEMADR, ov(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        ex("lw2.mrd",   S_MEMRD,  ov(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #1;
        ex("midrst", S_INIT, 16'h0000);
        chk("midrst.cnt", {12'd0, instr_cnt}, 16'd0);
        #3;
        rst_n = 1'b1;
        tick();
        fetch("post", 4'd0, OP_ORI, 6'd0);
        $display("[TB] %0d tests run, %0d failed", n, nf);
        $finish;
    end

endmodule
